pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Sequences the program counter: drives its mode/offset/target/load controls, sequencing them against an
//  instruction-memory request/ack handshake. Accepts branch/jump redirects from execute, stall and halt/resume.
//  Sits between the control/execute stages and the PC; PC advances only on an acknowledged, unstalled fetch.
//  Mode encoding: NORMAL=2'b00, BRANCH=2'b01, UCJUMP=2'b10, STOP_C=2'b11.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  address loaded into PC at boot
//  TIMEOUT    16             max cycles FETCH may wait for imem_ack before ERROR (>=2)
//  CNT_W      32             width of retired-fetch counter
// PORTS
//  clk        in   1      system clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset
//  imem_req   out  1      fetch request at current PC
//  imem_ack   in   1      imem has returned the instruction at current PC
//  stall      in   1      hold PC this cycle even if acked
//  br_req     in   1      one-cycle pulse: taken branch, PC-relative
//  br_off     in   32     branch offset (two's complement), valid with br_req
//  jmp_req    in   1      one-cycle pulse: absolute jump
//  jmp_tgt    in   32     jump target, valid with jmp_req
//  halt       in   1      stop fetching after current fetch completes
//  resume     in   1      leave HALTED
//  pc_load    out  1      active-high load strobe to PC (PC takes pc_target)
//  pc_mode    out  2      PC mode select
//  pc_offset  out  32     offset to PC adder (meaningful when pc_mode=BRANCH)
//  pc_target  out  32     target to PC (pc_load or pc_mode=UCJUMP)
//  fetch_cnt  out  CNT_W  number of PC advances since reset, wraps
//  err        out  1      sticky imem timeout flag
// BEHAVIOUR
//  Reset (rst=0, async): state=BOOT, pending regs cleared, fetch_cnt=0, wait_cnt=0, err=0;
//   outputs: imem_req=0, pc_mode=STOP_C, pc_load=1, pc_target=RESET_VEC, pc_offset=0.
//  States: BOOT, FETCH, HALTED, ERROR.
//  BOOT: pc_load=1, pc_target=RESET_VEC for exactly 1 cycle after rst release -> FETCH.
//  FETCH: imem_req=1. wait_cnt counts cycles without ack, cleared on ack.
//   advance = imem_ack & ~stall. If ~advance: pc_mode=STOP_C.
//   If advance: mode chosen by priority jump > branch > normal, where jump = jmp_req | jmp_pend,
//    branch = br_req | br_pend (live input beats pending of same kind). UCJUMP: pc_target=tgt;
//    BRANCH: pc_offset=off; NORMAL: PC+4. Consumed pending regs clear; fetch_cnt+1 (wraps).
//   If jump selected, any branch (live or pending) is discarded in the same cycle.
//   Redirect not consumed same cycle is latched: jmp_req sets jmp_pend/jmp_tgt_q (new overwrites old)
//    and clears br_pend; br_req sets br_pend/br_off_q only if no jump pending.
//   halt=1: if advance that cycle, advance completes then ->HALTED; else ->HALTED with no PC change.
//   wait_cnt reaches TIMEOUT-1 with no ack -> ERROR, err=1.
//  HALTED: imem_req=0, pc_mode=STOP_C; redirects still latch; resume=1 -> FETCH next cycle.
//   halt and resume both high in HALTED: stay HALTED.
//  ERROR: imem_req=0, pc_mode=STOP_C, err=1; exit only via rst.
//  pc_load=0 outside BOOT/reset. All outputs combinational from state+pending+inputs; no extra latency:
//   PC update occurs on the same posedge the ack is sampled.
//  Reset mid-fetch: request dropped immediately, pending redirects lost, PC reloaded to RESET_VEC.
// TESTING
//  Release rst; imem_ack tied 1 -> cycle 1 pc_load=1 tgt=RESET_VEC, then NORMAL each cycle, fetch_cnt=1,2,3.
//  ack delayed 3 cycles, stall high on ack cycle -> STOP_C until an ack with stall=0, then one NORMAL.
//  br_req(off=-8) while ack=0, ack 2 cycles later -> BRANCH with pc_offset=32'hFFFF_FFF8, br_pend cleared.
//  br_req(off=16) then jmp_req(tgt=0x100) before ack -> UCJUMP 0x100, branch discarded, next fetch NORMAL.
//  halt with ack same cycle -> one NORMAL then HALTED (imem_req=0); resume -> FETCH next cycle.
//  TIMEOUT=4, ack never -> err=1 after 4 FETCH cycles, STOP_C held; rst low->high -> BOOT, err=0.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the PC fetch sequencer and imem.
interface pc_fetch_sequencer_if;
  logic imem_req;
  logic imem_ack;

  modport master (output imem_req, input imem_ack);
  modport slave  (input imem_req, output imem_ack);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC fetch sequencer: steers PC mode/offset/target/load against the imem
// request/ack handshake, latching branch/jump redirects that arrive while the
// fetch cannot advance, and supporting stall, halt/resume and an ack timeout.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_fetch_sequencer_if.master imem,
  input  logic                 stall,
  input  logic                 br_req,
  input  logic [31:0]          br_off,
  input  logic                 jmp_req,
  input  logic [31:0]          jmp_tgt,
  input  logic                 halt,
  input  logic                 resume,
  output logic                 pc_load,
  output logic [1:0]           pc_mode,
  output logic [31:0]          pc_offset,
  output logic [31:0]          pc_target,
  output logic [CNT_W-1:0]     fetch_cnt,
  output logic                 err
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BRANCH = 2'b01,
    UCJUMP = 2'b10,
    STOP_C = 2'b11
  } pc_mode_e;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HALTED,
    S_ERROR
  } state_e;

  state_e            state;
  logic              jmp_pend;
  logic              br_pend;
  logic [31:0]       jmp_tgt_q;
  logic [31:0]       br_off_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;

  logic              advance;
  logic              sel_jmp;
  logic              sel_br;
  logic [31:0]       cur_tgt;
  logic [31:0]       cur_off;
  logic              lat_jmp_pend;
  logic              lat_br_pend;
  logic [31:0]       lat_tgt;
  logic [31:0]       lat_off;

  // Redirect selection and the pending-register values used when a redirect
  // is not consumed this cycle (jump overrides and discards any branch).
  always_comb begin
    advance      = (state == S_FETCH) && imem.imem_ack && !stall;
    sel_jmp      = jmp_req || jmp_pend;
    sel_br       = !sel_jmp && (br_req || br_pend);
    cur_tgt      = jmp_req ? jmp_tgt : jmp_tgt_q;
    cur_off      = br_req ? br_off : br_off_q;
    lat_jmp_pend = jmp_req || jmp_pend;
    lat_tgt      = jmp_req ? jmp_tgt : jmp_tgt_q;
    lat_br_pend  = !jmp_req && !jmp_pend && (br_req || br_pend);
    lat_off      = (br_req && !jmp_req && !jmp_pend) ? br_off : br_off_q;
  end

  // PC control outputs, combinational so the PC updates on the ack edge.
  always_comb begin
    pc_load   = 1'b0;
    pc_mode   = STOP_C;
    pc_offset = '0;
    pc_target = '0;
    unique case (state)
      S_BOOT: begin
        pc_load   = 1'b1;
        pc_target = RESET_VEC;
      end
      S_FETCH: begin
        if (advance) begin
          if (sel_jmp) begin
            pc_mode   = UCJUMP;
            pc_target = cur_tgt;
          end else if (sel_br) begin
            pc_mode   = BRANCH;
            pc_offset = cur_off;
          end else begin
            pc_mode   = NORMAL;
          end
        end
      end
      default: ;
    endcase
  end

  assign imem.imem_req = (state == S_FETCH);
  assign err           = err_q;

  // Sequencer FSM with pending redirects, ack-wait counter and retire count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_BOOT;
      jmp_pend  <= 1'b0;
      br_pend   <= 1'b0;
      jmp_tgt_q <= '0;
      br_off_q  <= '0;
      wait_cnt  <= '0;
      fetch_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state     <= S_FETCH;
          jmp_pend  <= lat_jmp_pend;
          br_pend   <= lat_br_pend;
          jmp_tgt_q <= lat_tgt;
          br_off_q  <= lat_off;
        end
        S_FETCH: begin
          if (advance) begin
            fetch_cnt <= fetch_cnt + 1'b1;
            jmp_pend  <= 1'b0;
            // A taken jump discards branches; a taken branch consumes its own.
            br_pend   <= 1'b0;
          end else begin
            jmp_pend  <= lat_jmp_pend;
            br_pend   <= lat_br_pend;
            jmp_tgt_q <= lat_tgt;
            br_off_q  <= lat_off;
          end
          if (imem.imem_ack) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          if (halt) begin
            state    <= S_HALTED;
          end else if (!imem.imem_ack && wait_cnt == WAIT_LAST) begin
            state    <= S_ERROR;
            err_q    <= 1'b1;
          end
        end
        S_HALTED: begin
          wait_cnt  <= '0;
          jmp_pend  <= lat_jmp_pend;
          br_pend   <= lat_br_pend;
          jmp_tgt_q <= lat_tgt;
          br_off_q  <= lat_off;
          if (resume && !halt) begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_ERROR;
          err_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer (RESET_VEC=0x1000, TIMEOUT=4).
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_req = 1'b0;
  logic [31:0] br_off = '0;
  logic        jmp_req = 1'b0;
  logic [31:0] jmp_tgt = '0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic        pc_load;
  logic [1:0]  pc_mode;
  logic [31:0] pc_offset;
  logic [31:0] pc_target;
  logic [31:0] fetch_cnt;
  logic        err;

  int total = 0;
  int bad   = 0;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_VEC (RV),
    .TIMEOUT   (4),
    .CNT_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (bus.master),
    .stall     (stall),
    .br_req    (br_req),
    .br_off    (br_off),
    .jmp_req   (jmp_req),
    .jmp_tgt   (jmp_tgt),
    .halt      (halt),
    .resume    (resume),
    .pc_load   (pc_load),
    .pc_mode   (pc_mode),
    .pc_offset (pc_offset),
    .pc_target (pc_target),
    .fetch_cnt (fetch_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the posedge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic load,
                         input logic [1:0] mode, input logic [31:0] tgt,
                         input logic [31:0] off);
    chk({tag, ".req"},  {63'd0, bus.imem_req}, {63'd0, req});
    chk({tag, ".load"}, {63'd0, pc_load},      {63'd0, load});
    chk({tag, ".mode"}, {62'd0, pc_mode},      {62'd0, mode});
    chk({tag, ".tgt"},  {32'd0, pc_target},    {32'd0, tgt});
    chk({tag, ".off"},  {32'd0, pc_offset},    {32'd0, off});
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    #1 rst = 1'b0;
    // reset state
    tick(); settle();
    chk_out("reset", 1'b0, 1'b1, 2'b11, RV, 32'h0);
    chk("reset.cnt", {32'd0, fetch_cnt}, 64'd0);
    chk("reset.err", {63'd0, err}, 64'd0);
    tick();
    // release reset mid-cycle with ack tied high: one BOOT cycle
    rst = 1'b1; bus.imem_ack = 1'b1; settle();
    chk_out("boot", 1'b0, 1'b1, 2'b11, RV, 32'h0);
    tick(); settle();
    chk_out("norm0", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("norm0.cnt", {32'd0, fetch_cnt}, 64'd0);
    tick(); settle();
    chk("norm1.cnt", {32'd0, fetch_cnt}, 64'd1);
    tick(); settle();
    chk("norm2.cnt", {32'd0, fetch_cnt}, 64'd2);
    tick();
    // delayed ack: three cycles without ack, then ack with stall
    bus.imem_ack = 1'b0; settle();
    chk("dly.cnt", {32'd0, fetch_cnt}, 64'd3);
    chk_out("dly0", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick(); settle();
    chk_out("dly1", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick(); settle();
    chk_out("dly2", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    bus.imem_ack = 1'b1; stall = 1'b1; settle();
    chk_out("stall", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    stall = 1'b0; settle();
    chk_out("unstall", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("unstall.cnt", {32'd0, fetch_cnt}, 64'd3);
    // branch latched while no ack, consumed two cycles later
    tick();
    bus.imem_ack = 1'b0; br_req = 1'b1; br_off = 32'hFFFF_FFF8; settle();
    chk("br.cnt", {32'd0, fetch_cnt}, 64'd4);
    chk_out("br_lat", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    br_req = 1'b0; br_off = '0; settle();
    chk_out("br_wait", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    bus.imem_ack = 1'b1; settle();
    chk_out("br_take", 1'b1, 1'b0, 2'b01, 32'h0, 32'hFFFF_FFF8);
    tick(); settle();
    chk_out("br_after", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("br_after.cnt", {32'd0, fetch_cnt}, 64'd5);
    // branch then jump before ack: jump wins, branch discarded
    tick();
    bus.imem_ack = 1'b0; br_req = 1'b1; br_off = 32'd16; settle();
    chk_out("bj_br", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    br_req = 1'b0; br_off = '0; jmp_req = 1'b1; jmp_tgt = 32'h100; settle();
    chk_out("bj_jmp", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    jmp_req = 1'b0; jmp_tgt = '0; bus.imem_ack = 1'b1; settle();
    chk_out("bj_take", 1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
    tick(); settle();
    chk_out("bj_after", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("bj_after.cnt", {32'd0, fetch_cnt}, 64'd7);
    // halt with ack in the same cycle: one NORMAL then HALTED
    tick();
    halt = 1'b1; settle();
    chk_out("halt_adv", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    halt = 1'b0; jmp_req = 1'b1; jmp_tgt = 32'h200; settle();
    chk_out("halted", 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    chk("halted.cnt", {32'd0, fetch_cnt}, 64'd9);
    tick();
    jmp_req = 1'b0; jmp_tgt = '0; halt = 1'b1; resume = 1'b1; settle();
    chk_out("halt_both", 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    halt = 1'b0; settle();
    chk_out("halt_both_after", 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    tick();
    resume = 1'b0; settle();
    chk_out("resumed", 1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    chk("resumed.cnt", {32'd0, fetch_cnt}, 64'd9);
    tick(); settle();
    chk("resumed2.cnt", {32'd0, fetch_cnt}, 64'd10);
    // timeout: ack never arrives during four FETCH cycles
    bus.imem_ack = 1'b0; settle();
    chk_out("to0", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    tick(); tick(); tick(); settle();
    chk_out("to3", 1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    chk("to3.err", {63'd0, err}, 64'd0);
    tick(); settle();
    chk_out("error", 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    chk("error.err", {63'd0, err}, 64'd1);
    tick();
    bus.imem_ack = 1'b1; settle();
    tick(); settle();
    chk_out("error_hold", 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    chk("error_hold.err", {63'd0, err}, 64'd1);
    chk("error_hold.cnt", {32'd0, fetch_cnt}, 64'd10);
    // asynchronous reset mid-cycle recovers to BOOT
    rst = 1'b0; settle();
    chk_out("rst2", 1'b0, 1'b1, 2'b11, RV, 32'h0);
    chk("rst2.err", {63'd0, err}, 64'd0);
    chk("rst2.cnt", {32'd0, fetch_cnt}, 64'd0);
    tick();
    rst = 1'b1; settle();
    chk_out("boot2", 1'b0, 1'b1, 2'b11, RV, 32'h0);
    tick(); settle();
    chk_out("fetch2", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    tick(); settle();
    chk("fetch2.cnt", {32'd0, fetch_cnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
